// File: rtl/cargo_stop_scheduler.sv
// cargo_stop_scheduler: stop queue and door-dwell sequencer; define CARGO_FIT_EN for in-route (carona) insertion
module cargo_stop_scheduler #(
  parameter int FLOORS       = 4,
  parameter int FLOOR_W      = 2,
  parameter int TYPE_W       = 2,
  parameter int DEPTH        = 16,
  parameter int DWELL_CYCLES = 2000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [FLOOR_W-1:0]       req_origin,
  input  logic [FLOOR_W-1:0]       req_dest,
  input  logic [TYPE_W-1:0]        req_type,
  input  logic [FLOOR_W-1:0]       cur_floor,
  output logic                     stop_valid,
  output logic [FLOOR_W-1:0]       stop_floor,
  output logic                     stop_is_origin,
  output logic [TYPE_W-1:0]        stop_type,
  output logic                     going_up,
  output logic                     door_open,
  output logic                     served,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_req
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 1 + TYPE_W + FLOOR_W;
  localparam int TW = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(DWELL_CYCLES - 1);
  localparam logic [FLOOR_W:0] FL = (FLOOR_W + 1)'(FLOORS);
  localparam logic [AW:0] ROOM = (AW + 1)'(DEPTH - 2);
  typedef enum logic [2:0] {IDLE, SCAN_O, INS_O, SCAN_D, INS_D} ins_t;
  typedef enum logic [1:0] {WAIT, DWELL, POP} svc_t;
  ins_t ins_state;
  svc_t svc_state;
  logic [EW-1:0] ent [DEPTH];
  logic [FLOOR_W-1:0] p_org, p_dst, ins_floor;
  logic [TYPE_W-1:0] p_typ;
  logic [TW-1:0] timer;
  logic [AW:0] ins_pos;
  logic accept, bad, pop_now, ins_idle, dwell_go, leave;
  assign accept    = req_valid && req_ready;
  assign bad       = req_origin == req_dest || {1'b0, req_origin} >= FL || {1'b0, req_dest} >= FL;
  assign pop_now   = svc_state == POP;
  assign ins_idle  = ins_state == IDLE;
  assign req_ready = ins_idle && count <= ROOM && !pop_now;
  assign stop_valid = count != '0;
  assign {stop_is_origin, stop_type, stop_floor} = ent[0];
  assign going_up  = stop_floor > cur_floor;
  assign ins_floor = (ins_state == SCAN_O || ins_state == INS_O) ? p_org : p_dst;
  assign dwell_go  = svc_state == WAIT && stop_valid && cur_floor == stop_floor && ins_idle;
  // a request accepted in the same cycle holds the dwell so a pop never overlaps an insertion
  assign leave     = timer == LAST && ins_idle && !accept;
`ifdef CARGO_FIT_EN
  logic [AW:0] idx, pos;
  logic [AW-1:0] im1;
  logic [FLOOR_W-1:0] a, b;
  logic p_up, fit;
  assign im1     = AW'(idx - 1'b1);
  assign a       = idx == '0 ? cur_floor : ent[im1][FLOOR_W-1:0];
  assign b       = ent[idx[AW-1:0]][FLOOR_W-1:0];
  assign fit     = idx < count && (p_up ? (a < ins_floor && ins_floor < b) : (a > ins_floor && ins_floor > b));
  assign ins_pos = pos;
`else
  assign ins_pos = count;
`endif
  // stop storage, request intake and the insert FSM; pops shift the queue toward the head
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      ins_state <= IDLE;
      count <= '0;
      err_req <= 1'b0;
      p_org <= '0;
      p_dst <= '0;
      p_typ <= '0;
      for (int j = 0; j < DEPTH; j++) ent[j] <= '0;
`ifdef CARGO_FIT_EN
      idx <= '0;
      pos <= '0;
      p_up <= 1'b0;
`endif
    end else begin
      err_req <= accept && bad;
      if (pop_now) begin
        for (int j = 0; j < DEPTH - 1; j++) ent[j] <= ent[j + 1];
        count <= count - 1'b1;
      end
      case (ins_state)
        IDLE: if (accept && !bad) begin
          p_org <= req_origin;
          p_dst <= req_dest;
          p_typ <= req_type;
`ifdef CARGO_FIT_EN
          p_up <= req_dest > req_origin;
          idx <= (door_open || dwell_go) ? (AW + 1)'(1) : '0;
          ins_state <= SCAN_O;
`else
          ins_state <= INS_O;
`endif
        end
`ifdef CARGO_FIT_EN
        SCAN_O, SCAN_D: if (fit || idx == count) begin
          pos <= idx;
          ins_state <= ins_state == SCAN_O ? INS_O : INS_D;
        end else idx <= idx + 1'b1;
`endif
        INS_O, INS_D: begin
          for (int j = 1; j < DEPTH; j++)
            if ((AW + 1)'(j) > ins_pos && (AW + 1)'(j) <= count) ent[j] <= ent[j - 1];
          ent[ins_pos[AW-1:0]] <= {ins_state == INS_O, p_typ, ins_floor};
          count <= count + 1'b1;
`ifdef CARGO_FIT_EN
          idx <= pos + 1'b1;
          ins_state <= ins_state == INS_O ? SCAN_D : IDLE;
`else
          ins_state <= ins_state == INS_O ? INS_D : IDLE;
`endif
        end
        default: ins_state <= IDLE;
      endcase
    end
  // service FSM: open the door at the head stop, run the dwell timer, then pop
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      svc_state <= WAIT;
      timer <= '0;
      door_open <= 1'b0;
      served <= 1'b0;
    end else begin
      served <= pop_now;
      case (svc_state)
        WAIT: if (dwell_go) begin
          svc_state <= DWELL;
          timer <= '0;
          door_open <= 1'b1;
        end
        DWELL: if (leave) begin
          svc_state <= POP;
          door_open <= 1'b0;
        end else if (timer != LAST) timer <= timer + 1'b1;
        POP: svc_state <= WAIT;
        default: svc_state <= WAIT;
      endcase
    end
endmodule

// File: tb/tb_cargo_stop_scheduler.sv
// tb_cargo_stop_scheduler: randomized requests against a queue-level reference model
module tb_cargo_stop_scheduler;
  localparam int FLOORS = 4, FLOOR_W = 3, TYPE_W = 2, DEPTH = 8, DWELL = 4;
  logic clock = 0, reset_n = 0, req_valid = 0;
  logic [FLOOR_W-1:0] req_origin = 0, req_dest = 0, cur_floor = 0;
  logic [TYPE_W-1:0] req_type = 0;
  logic req_ready, stop_valid, stop_is_origin, going_up, door_open, served, err_req;
  logic [FLOOR_W-1:0] stop_floor;
  logic [TYPE_W-1:0] stop_type;
  logic [$clog2(DEPTH):0] count;
  logic [5:0] q[$];
  int cf = 0, n_chk = 0, n_pass = 0;
  bit door_q = 0;

  always #5 clock = ~clock;

  cargo_stop_scheduler #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W), .TYPE_W(TYPE_W), .DEPTH(DEPTH), .DWELL_CYCLES(DWELL)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_origin(req_origin), .req_dest(req_dest), .req_type(req_type), .cur_floor(cur_floor),
    .stop_valid(stop_valid), .stop_floor(stop_floor), .stop_is_origin(stop_is_origin),
    .stop_type(stop_type), .going_up(going_up), .door_open(door_open), .served(served),
    .count(count), .err_req(err_req));

  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    if (door_open && !door_q) begin
      check("dwell_head", {stop_is_origin, stop_type, stop_floor}, q.size() > 0 ? int'(q[0]) : -1);
      check("dwell_floor", stop_floor, cf);
    end
    if (served) begin
      if (q.size() > 0) void'(q.pop_front());
      check("served_count", count, q.size());
    end
    door_q = door_open;
  endtask

`ifdef CARGO_FIT_EN
  function automatic int find_pos(int start, int f, bit up);
    for (int i = start; i < q.size(); i++) begin
      int a = i == 0 ? cf : int'(q[i - 1][2:0]);
      int b = q[i][2:0];
      if (up ? (a < f && f < b) : (a > f && f > b)) return i;
    end
    return q.size();
  endfunction
`endif

  task automatic send(int o, int d, int t);
    bit bad = o == d || o >= FLOORS || d >= FLOORS;
    bit acc = 0, rdy;
    req_origin = 3'(o);
    req_dest = 3'(d);
    req_type = 2'(t);
    req_valid = 1;
    for (int k = 0; k < 400 && !acc; k++) begin
      rdy = req_ready;
      tick();
      acc = rdy;
    end
    req_valid = 0;
    if (!acc) begin
      check("req_timeout", 0, 1);
      return;
    end
    check("err_req", err_req, bad);
    if (!bad) begin
`ifdef CARGO_FIT_EN
      bit lock = q.size() > 0 && int'(q[0][2:0]) == cf;
      int po = find_pos(lock ? 1 : 0, o, d > o);
      q.insert(po, {1'b1, 2'(t), 3'(o)});
      q.insert(find_pos(po + 1, d, d > o), {1'b0, 2'(t), 3'(d)});
`else
      q.push_back({1'b1, 2'(t), 3'(o)});
      q.push_back({1'b0, 2'(t), 3'(d)});
`endif
    end
  endtask

  task automatic settle();
    int k = 0;
    while (k < 3000 && !((q.size() == 0 || int'(q[0][2:0]) != cf) && !door_open)) begin
      tick();
      k++;
    end
    if (k == 3000) check("settle_timeout", 0, 1);
    repeat (2 * DEPTH + 6) tick();
    check("count", count, q.size());
    check("stop_valid", stop_valid, q.size() > 0);
    check("door_idle", door_open, 0);
    check("req_ready", req_ready, q.size() <= DEPTH - 2);
    if (q.size() > 0) begin
      check("head", {stop_is_origin, stop_type, stop_floor}, q[0]);
      check("going_up", going_up, int'(q[0][2:0]) > cf);
    end
  endtask

  function automatic int rnd_floor();
    return $urandom_range(0, 9) == 0 ? 7 : $urandom_range(0, FLOORS - 1);
  endfunction

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clock);
    check("rst_stop_valid", stop_valid, 0);
    check("rst_door_open", door_open, 0);
    check("rst_served", served, 0);
    check("rst_err_req", err_req, 0);
    check("rst_count", count, 0);
    reset_n = 1;
    @(negedge clock);
    check("rst_ready", req_ready, 1);
    send(0, 3, 2);
    settle();
    send(2, 2, 1);
    send(0, 5, 1);
    settle();
    send(1, 2, 0);
    settle();
    for (int e = 0; e < 80; e++) begin
      cf = $urandom_range(0, FLOORS - 1);
      if ($urandom_range(0, 3) == 0 && q.size() > 0) cf = q[0][2:0];
      cur_floor = 3'(cf);
      repeat ($urandom_range(1, 3))
        if (q.size() <= DEPTH - 2) send(rnd_floor(), rnd_floor(), $urandom_range(0, 3));
      settle();
    end
    reset_n = 0;
    @(negedge clock);
    reset_n = 1;
    q.delete();
    door_q = 0;
    cf = 0;
    cur_floor = 0;
    @(negedge clock);
    send(1, 2, 0);
    send(3, 2, 1);
    settle();
    send(2, 3, 3);
    reset_n = 0;
    #1;
    check("midrst_count", count, 0);
    check("midrst_stop_valid", stop_valid, 0);
    check("midrst_door", door_open, 0);
    @(negedge clock);
    reset_n = 1;
    q.delete();
    door_q = 0;
    tick();
    check("midrst_ready", req_ready, 1);
    check("midrst_count_after", count, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
